// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//
// Purpose:
//   Steps an external interval timer through a programmable table of
//   intervals. For every non-zero table entry a one-cycle start pulse is
//   issued together with the interval on timer_para; the sequencer then
//   waits for the timer's timeup pulse before moving on. Zero entries are
//   skipped in a single cycle without arming the timer. A run can be
//   cancelled at any time with seq_abort.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   cfg_we       table write strobe (ignored while busy)
//   cfg_addr     table write address
//   cfg_data     interval value to write
//   cfg_len      number of steps, sampled when a run is accepted
//   seq_start    one-cycle request to run the sequence
//   seq_abort    level, cancels a running sequence
//   timeup       one-cycle completion pulse from the timer
//   start        one-cycle arm pulse to the timer
//   timer_para   interval presented to the timer
//   step_idx     index of the current step
//   busy         high while a run is in progress
//   seq_done     one-cycle pulse on normal completion
//   seq_aborted  one-cycle pulse when a run is aborted
// ---------------------------------------------------------------------------
module timer_sequencer #(
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [PW-1:0]            cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     seq_start,
  input  logic                     seq_abort,
  input  logic                     timeup,
  output logic                     start,
  output logic [PW-1:0]            timer_para,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     seq_aborted
);

  localparam int AW = $clog2(DEPTH);

  // DEPTH expressed in the width of cfg_len so range checks need no casts.
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_reg;
  logic [AW:0]    len_reg;

  // -------------------------------------------------------------------------
  // Interval table. Not reset: contents are only meaningful once written.
  // The read is combinational because ARM must act on table[step_idx] in
  // the same cycle step_idx becomes valid; at these depths it maps to
  // distributed memory.
  // -------------------------------------------------------------------------
  logic [PW-1:0]  table_mem [DEPTH];
  logic           addr_in_range;
  logic [PW-1:0]  cur_entry;

  // Guards non-power-of-two depths where cfg_addr can exceed DEPTH-1.
  assign addr_in_range = ({1'b0, cfg_addr} < LEN_MAX);

  always_ff @(posedge clk) begin
    if (cfg_we && !busy && addr_in_range) begin
      table_mem[cfg_addr] <= cfg_data;
    end
  end

  assign cur_entry = table_mem[step_idx];

  // -------------------------------------------------------------------------
  // Step bookkeeping
  // -------------------------------------------------------------------------
  logic [AW:0]    step_count;   // step_idx + 1, one bit wider so it cannot wrap
  logic           last_step;
  logic           len_ok;

  assign step_count = {1'b0, step_idx} + (AW+1)'(1);
  assign last_step  = (step_count >= len_reg);
  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  // -------------------------------------------------------------------------
  // Control FSM; every output is a register written here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;
      timer_para  <= '0;
      step_idx    <= '0;
    end else begin
      // Pulse outputs default low; each branch raises them for one cycle.
      start       <= 1'b0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;

      if (busy && seq_abort) begin
        // Abort wins over anything else happening this cycle, including
        // a coincident timeup.
        state_reg   <= IDLE;
        busy        <= 1'b0;
        seq_aborted <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (seq_start) begin
              if (len_ok) begin
                len_reg   <= cfg_len;
                step_idx  <= '0;
                busy      <= 1'b1;
                state_reg <= ARM;
              end else begin
                // Empty or oversize run: report completion immediately
                // without ever arming the timer.
                seq_done <= 1'b1;
              end
            end
          end

          ARM: begin
            if (cur_entry != '0) begin
              start      <= 1'b1;
              timer_para <= cur_entry;
              state_reg  <= WAIT;
            end else if (last_step) begin
              state_reg <= DONE;
            end else begin
              // Zero interval: skip this step, stay in ARM for the next one.
              step_idx <= step_idx + AW'(1);
            end
          end

          WAIT: begin
            if (timeup) begin
              if (last_step) begin
                state_reg <= DONE;
              end else begin
                step_idx  <= step_idx + AW'(1);
                state_reg <= ARM;
              end
            end
          end

          DONE: begin
            // step_idx and timer_para intentionally keep their last values.
            seq_done  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end

          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
